// File: rtl/touch_grid_selector.sv
// Touch-panel grid option selector: maps a ROWS x COLS grid of touch rectangles to
// per-cell codes behind a wait-for-release arming step and a hold-time confirmation filter.
module touch_grid_selector #(
  parameter int unsigned ROWS          = 2,
  parameter int unsigned COLS          = 3,
  parameter int unsigned CODE_W        = 3,
  parameter logic [ROWS*COLS*CODE_W-1:0] CODES =
    {3'b110, 3'b111, 3'b011, 3'b010, 3'b101, 3'b100},
  parameter int          X_FIRST       = 1923,
  parameter int          X_PITCH       = -597,
  parameter int          X_LEN         = 568,
  parameter int          Y_FIRST       = 1808,
  parameter int          Y_PITCH       = -823,
  parameter int          Y_LEN         = 748,
  parameter int unsigned SETTLE_CYCLES = 15000,
  parameter int unsigned HOLD_CYCLES   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active,
  input  logic [11:0]       x_touch,
  input  logic [11:0]       y_touch,
  input  logic              touch_input,
  output logic              hover_valid,
  output logic [5:0]        hover_index,
  output logic [CODE_W-1:0] sel_code,
  output logic [5:0]        sel_index,
  output logic              sel_valid,
  output logic              done,
  output logic              busy
);

  localparam int unsigned CELLS   = ROWS * COLS;
  localparam int unsigned IDX_W   = 6;
  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_ARMED, S_CONFIRM, S_DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  cand;
  logic [CELLS-1:0]  hit;
  logic [IDX_W-1:0]  hit_idx_c;
  logic              one_hit_c;
  logic              valid_c;
  logic [CODE_W-1:0] code_tab [64];

  // Per-cell rectangle test; upper bounds may reach 4096 so compare at 13 bits.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int XLO = X_FIRST + c * X_PITCH;
      localparam int XHI = XLO + X_LEN;
      localparam int YLO = Y_FIRST + r * Y_PITCH;
      localparam int YHI = YLO + Y_LEN;
      if (XLO < 0 || XHI > 4096 || YLO < 0 || YHI > 4096) begin : g_bad
        $error("touch_grid_selector: cell bound outside 0..4096");
      end
      assign hit[r*COLS+c] = ({1'b0, x_touch} >= 13'(XLO)) && ({1'b0, x_touch} < 13'(XHI)) &&
                             ({1'b0, y_touch} >= 13'(YLO)) && ({1'b0, y_touch} < 13'(YHI));
    end
  end

  for (genvar i = 0; i < 64; i++) begin : g_code
    if (i < CELLS) begin : g_used
      assign code_tab[i] = CODES[i*CODE_W +: CODE_W];
    end else begin : g_unused
      assign code_tab[i] = '0;
    end
  end

  // Overlapping hits are rejected, so the index is only meaningful for a one-hot vector.
  always_comb begin
    hit_idx_c = '0;
    one_hit_c = (hit != '0) && ((hit & (hit - CELLS'(1))) == '0);
    for (int unsigned i = 0; i < CELLS; i++) begin
      if (hit[i]) hit_idx_c = IDX_W'(i);
    end
    valid_c = touch_input && one_hit_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      cand        <= '0;
      hover_valid <= 1'b0;
      hover_index <= '0;
      sel_code    <= '0;
      sel_index   <= '0;
      sel_valid   <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      hover_valid <= valid_c;
      hover_index <= valid_c ? hit_idx_c : '0;
      sel_valid   <= 1'b0;
      if (!active) begin
        state     <= S_IDLE;
        cnt       <= '0;
        cand      <= '0;
        sel_code  <= '0;
        sel_index <= '0;
        done      <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            state <= S_SETTLE;
            cnt   <= CNT_W'(SETTLE_CYCLES - 1);
            busy  <= 1'b1;
          end
          S_SETTLE: begin
            // A touch still held when blanking ends must be released before arming.
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else if (!touch_input) begin
              state <= S_ARMED;
              busy  <= 1'b0;
            end
          end
          S_ARMED: begin
            if (valid_c) begin
              cand <= hit_idx_c;
              if (HOLD_CYCLES <= 1) begin
                state     <= S_DONE;
                sel_code  <= code_tab[hit_idx_c];
                sel_index <= hit_idx_c;
                sel_valid <= 1'b1;
                done      <= 1'b1;
              end else begin
                state <= S_CONFIRM;
                cnt   <= CNT_W'(HOLD_CYCLES - 1);
                busy  <= 1'b1;
              end
            end
          end
          S_CONFIRM: begin
            // cnt holds the identical samples still owed; the last one confirms.
            if (valid_c && hit_idx_c == cand) begin
              if (cnt <= CNT_W'(1)) begin
                state     <= S_DONE;
                cnt       <= '0;
                sel_code  <= code_tab[cand];
                sel_index <= cand;
                sel_valid <= 1'b1;
                done      <= 1'b1;
                busy      <= 1'b0;
              end else begin
                cnt <= cnt - CNT_W'(1);
              end
            end else begin
              state <= S_ARMED;
              cand  <= '0;
              cnt   <= '0;
              busy  <= 1'b0;
            end
          end
          S_DONE: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_touch_grid_selector.sv
// Directed bench for touch_grid_selector: default geometry, a short-settle copy and a
// 1x2 single-sample-confirm variant all driven from the same stimulus.
module tb_touch_grid_selector;

  logic        clk = 1'b0;
  logic        rst;
  logic        active;
  logic [11:0] x_touch;
  logic [11:0] y_touch;
  logic        touch_input;

  logic       a_hv, a_sv, a_done, a_busy;
  logic [5:0] a_hi, a_si;
  logic [2:0] a_code;
  logic       b_hv, b_sv, b_done, b_busy;
  logic [5:0] b_hi, b_si;
  logic [2:0] b_code;
  logic       c_hv, c_sv, c_done, c_busy;
  logic [5:0] c_hi, c_si;
  logic [2:0] c_code;

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  touch_grid_selector dut_a (
    .clk(clk), .rst(rst), .active(active), .x_touch(x_touch), .y_touch(y_touch),
    .touch_input(touch_input), .hover_valid(a_hv), .hover_index(a_hi), .sel_code(a_code),
    .sel_index(a_si), .sel_valid(a_sv), .done(a_done), .busy(a_busy)
  );

  touch_grid_selector #(.SETTLE_CYCLES(8)) dut_b (
    .clk(clk), .rst(rst), .active(active), .x_touch(x_touch), .y_touch(y_touch),
    .touch_input(touch_input), .hover_valid(b_hv), .hover_index(b_hi), .sel_code(b_code),
    .sel_index(b_si), .sel_valid(b_sv), .done(b_done), .busy(b_busy)
  );

  touch_grid_selector #(.ROWS(1), .COLS(2), .CODES({3'b011, 3'b101}),
                        .SETTLE_CYCLES(4), .HOLD_CYCLES(1)) dut_c (
    .clk(clk), .rst(rst), .active(active), .x_touch(x_touch), .y_touch(y_touch),
    .touch_input(touch_input), .hover_valid(c_hv), .hover_index(c_hi), .sel_code(c_code),
    .sel_index(c_si), .sel_valid(c_sv), .done(c_done), .busy(c_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic touch(input logic [11:0] x, input logic [11:0] y);
    x_touch = x; y_touch = y; touch_input = 1'b1;
  endtask

  task automatic release_touch();
    touch_input = 1'b0; x_touch = '0; y_touch = '0;
  endtask

  initial begin
    rst = 1'b1; active = 1'b0; release_touch();
    tick(2);
    check("rst_busy",  32'(a_busy), 0);
    check("rst_done",  32'(a_done), 0);
    check("rst_code",  32'(a_code), 0);
    check("rst_hover", 32'(a_hv), 0);
    rst = 1'b0;
    tick();

    // Full-length settle on the default instance.
    active = 1'b1;
    tick();
    check("settle_busy_start", 32'(a_busy), 1);
    tick(14999);
    check("settle_busy_last", 32'(a_busy), 1);
    tick();
    check("settle_armed", 32'(a_busy), 0);

    touch(12'd1910, 12'd1900);
    tick();
    check("gap_x_hover", 32'(a_hv), 0);
    check("gap_x_busy",  32'(a_busy), 0);
    touch(12'd2000, 12'd1770);
    tick();
    check("gap_y_hover", 32'(a_hv), 0);
    check("gap_y_busy",  32'(a_busy), 0);

    touch(12'd2000, 12'd1900);
    tick();
    check("c0_hover_valid", 32'(a_hv), 1);
    check("c0_hover_index", 32'(a_hi), 0);
    check("c0_confirm_busy", 32'(a_busy), 1);
    tick(2);
    check("c0_no_early_sel", 32'(a_sv), 0);
    tick();
    check("c0_sel_valid", 32'(a_sv), 1);
    check("c0_sel_code",  32'(a_code), 32'b100);
    check("c0_sel_index", 32'(a_si), 0);
    check("c0_done",      32'(a_done), 1);
    tick();
    check("c0_strobe_once", 32'(a_sv), 0);
    check("c0_code_held",   32'(a_code), 32'b100);

    release_touch(); active = 1'b0;
    tick();
    check("deact_done", 32'(a_done), 0);
    check("deact_code", 32'(a_code), 0);

    // Touch held across activation must not select until released.
    touch(12'd1400, 12'd1000); active = 1'b1;
    tick(20);
    check("held_busy",       32'(b_busy), 1);
    check("held_done",       32'(b_done), 0);
    check("held_hover",      32'(b_hi), 4);
    release_touch();
    tick();
    check("held_release_armed", 32'(b_busy), 0);
    touch(12'd1400, 12'd1000);
    tick(3);
    check("c4_no_early_sel", 32'(b_sv), 0);
    tick();
    check("c4_sel_valid", 32'(b_sv), 1);
    check("c4_sel_code",  32'(b_code), 32'b111);
    check("c4_sel_index", 32'(b_si), 4);

    // Switching cells mid-confirm drops the candidate back to ARMED.
    release_touch(); active = 1'b0;
    tick();
    active = 1'b1;
    tick(9);
    check("sw_armed", 32'(b_busy), 0);
    touch(12'd800, 12'd1900);
    tick(3);
    check("sw_c2_busy", 32'(b_busy), 1);
    check("sw_c2_nosel", 32'(b_sv), 0);
    touch(12'd1400, 12'd1900);
    tick();
    check("sw_back_armed", 32'(b_busy), 0);
    tick(3);
    check("sw_c1_nosel", 32'(b_sv), 0);
    tick();
    check("sw_c1_sel_valid", 32'(b_sv), 1);
    check("sw_c1_sel_code",  32'(b_code), 32'b101);
    check("sw_c1_sel_index", 32'(b_si), 1);

    // Abort coinciding with the confirming sample wins.
    release_touch(); active = 1'b0;
    tick();
    active = 1'b1;
    tick(9);
    touch(12'd2000, 12'd1900);
    tick(3);
    active = 1'b0;
    tick();
    check("abort_sel_valid", 32'(b_sv), 0);
    check("abort_done",      32'(b_done), 0);
    check("abort_code",      32'(b_code), 0);

    // Async reset mid-CONFIRM (dut_b) and mid-DONE (dut_c).
    release_touch(); active = 1'b1;
    tick(9);
    touch(12'd2000, 12'd1900);
    tick();
    check("c_single_sel_valid", 32'(c_sv), 1);
    check("c_single_sel_code",  32'(c_code), 32'b101);
    check("c_single_sel_index", 32'(c_si), 0);
    tick();
    check("pre_rst_busy", 32'(b_busy), 1);
    check("pre_rst_c_done", 32'(c_done), 1);
    rst = 1'b1;
    #1;
    check("rst_mid_busy",  32'(b_busy), 0);
    check("rst_mid_hover", 32'(b_hv), 0);
    check("rst_mid_c_done", 32'(c_done), 0);
    check("rst_mid_c_code", 32'(c_code), 0);
    tick();
    rst = 1'b0; release_touch();
    tick();

    // 1x2 grid: one sample on cell 1 confirms.
    tick(5);
    check("c_armed", 32'(c_busy), 0);
    touch(12'd1400, 12'd1900);
    tick();
    check("c1_sel_valid", 32'(c_sv), 1);
    check("c1_sel_code",  32'(c_code), 32'b011);
    check("c1_sel_index", 32'(c_si), 1);
    check("c1_done",      32'(c_done), 1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
